sprite_palette_engine: RTL and testbench
========================================

SPRITE_PALETTE_ENGINE -- requirements
Module: sprite_palette_engine

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning color-index width (2**INDEX_W entries per palette).
REQ-002 SHALL have parameter NUM_PAL, default 4, meaning number of selectable palettes (power of two, >=2).
REQ-003 SHALL have parameter CH_W, default 4, meaning bits per color channel.
REQ-004 SHALL have parameter FLASH_W, default 6, meaning flash frame-counter width.
REQ-005 SHALL have port Clk, input, 1, meaning the only clock; all logic is rising-edge.
REQ-006 SHALL have port Reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, meaning a palette entry write this cycle.
REQ-008 SHALL have port wr_pal, input, $clog2(NUM_PAL), meaning the palette to write.
REQ-009 SHALL have port wr_index, input, INDEX_W, meaning the entry to write.
REQ-010 SHALL have port wr_rgb, input, 3*CH_W, meaning {r,g,b} write data.
REQ-011 SHALL have port rd_valid, input, 1, meaning a lookup request.
REQ-012 SHALL have port rd_pal, input, $clog2(NUM_PAL), meaning the palette for the lookup.
REQ-013 SHALL have port rd_index, input, INDEX_W, meaning the pixel color index.
REQ-014 SHALL have port frame_tick, input, 1, meaning a one-cycle pulse per frame (vsync edge).
REQ-015 SHALL have port flash_start, input, 1, meaning a pulse that starts a hit-flash.
REQ-016 SHALL have port flash_frames, input, FLASH_W, meaning flash duration in frames, sampled with flash_start.
REQ-017 SHALL have port fade_shift, input, 2, meaning brightness right-shift applied to every channel.
REQ-018 SHALL have ports out_valid (output, 1) and transparent (output, 1).
REQ-019 SHALL have ports red, green, blue, output, CH_W each.
REQ-020 SHALL have port flash_active, output, 1, meaning the flash FSM is not IDLE.

Function
REQ-021 Storage SHALL be NUM_PAL*2**INDEX_W entries of 3*CH_W bits, written on the rising edge when wr_en=1.
REQ-022 Lookup latency SHALL be exactly 1 cycle: out_valid(t+1)=rd_valid(t), and the outputs are registered.
REQ-023 When out_valid=0, red/green/blue/transparent SHALL be 0.
REQ-024 A same-cycle write and read of the same {pal,index} SHALL return the old (pre-write) data.
REQ-025 rd_index==0 SHALL give transparent=1 with rgb=0; no fade or flash is applied.
REQ-026 For a non-transparent index, each channel SHALL be the stored channel >> fade_shift (logical shift, zero-fill), with fade_shift sampled in the request cycle.
REQ-027 The flash FSM SHALL have three states: IDLE, FLASH_ON, FLASH_OFF, plus a frame counter cnt.
REQ-028 flash_start with flash_frames!=0 in any state SHALL load cnt=flash_frames and enter FLASH_ON next cycle, so a flash restarts mid-flash.
REQ-029 flash_start with flash_frames==0 SHALL go to IDLE.
REQ-030 On frame_tick (without flash_start) in FLASH_ON/FLASH_OFF, cnt SHALL decrement; cnt reaching 0 SHALL go to IDLE, otherwise the state toggles ON<->OFF.
REQ-031 flash_start simultaneous with frame_tick SHALL take priority; the tick is ignored.
REQ-032 While FLASH_ON is the state in the request cycle, non-transparent outputs SHALL be all channels max ({CH_W{1}}), ignoring fade.
REQ-033 flash_active SHALL be 1 in FLASH_ON and FLASH_OFF.

Reset
REQ-034 Reset_n=0 SHALL asynchronously clear all storage to 0, set state IDLE and cnt=0, and drive out_valid, transparent, rgb, and flash_active to 0.
REQ-035 A lookup or write in flight during reset SHALL be discarded; operation resumes on the first edge after deassertion.

Structure
REQ-036 A shared package SHALL hold the flash state enum and default CH_W/INDEX_W constants.
REQ-037 The flash FSM SHALL be one sub-module, palette_flash_fsm.

Verification
REQ-038 Write pal1/idx5=0xC58, then read pal1/idx5 with fade_shift=0 -> next cycle out_valid=1, rgb=C,5,8, transparent=0.
REQ-039 Same entry read with fade_shift=2 -> rgb=3,1,2; read of idx0 -> transparent=1, rgb=0.
REQ-040 Write and read pal0/idx3 in the same cycle (old=0x000, new=0xFFF) -> 0x000; re-read -> 0xFFF.
REQ-041 flash_start with frames=3, then 3 frame_ticks -> states ON,OFF,ON,IDLE; non-zero idx reads F,F,F only in ON.
REQ-042 Second flash_start(frames=2) during FLASH_OFF with a coincident frame_tick -> FLASH_ON, cnt=2.
REQ-043 Reset_n pulsed low mid-flash after writes -> flash_active=0 and every entry reads 0.

Source files
------------

// File: rtl/sprite_palette_engine_pkg.sv
// Shared types and default sizes for the sprite palette engine.
// Holds the hit-flash state encoding used by the top and the flash FSM.
package sprite_palette_engine_pkg;

  localparam int DEF_CH_W    = 4;
  localparam int DEF_INDEX_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_e;

endpackage

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: alternates ON/OFF once per frame for a programmed
// number of frames; a new start always reloads and restarts the flash.
module palette_flash_fsm
  import sprite_palette_engine_pkg::*;
#(
  parameter int FLASH_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               flash_start,
  input  logic [FLASH_W-1:0] flash_frames,
  output flash_state_e       state,
  output logic               flash_active
);

  flash_state_e       state_r, state_n;
  logic [FLASH_W-1:0] cnt_r, cnt_n, cnt_dec_s;
  logic               active_r;

  // Next-state: start wins over a coincident frame tick.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    cnt_dec_s = cnt_r - {{(FLASH_W-1){1'b0}}, 1'b1};
    if (flash_start) begin
      if (flash_frames != {FLASH_W{1'b0}}) begin
        state_n = FLASH_ON;
        cnt_n   = flash_frames;
      end else begin
        state_n = IDLE;
        cnt_n   = {FLASH_W{1'b0}};
      end
    end else if (frame_tick) begin
      case (state_r)
        FLASH_ON, FLASH_OFF: begin
          cnt_n = cnt_dec_s;
          if (cnt_dec_s == {FLASH_W{1'b0}}) begin
            state_n = IDLE;
          end else if (state_r == FLASH_ON) begin
            state_n = FLASH_OFF;
          end else begin
            state_n = FLASH_ON;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = {FLASH_W{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
      cnt_n   = cnt_r;
    end
  end

  // State, counter and registered activity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {FLASH_W{1'b0}};
      active_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      active_r <= (state_n == FLASH_ON) || (state_n == FLASH_OFF);
    end
  end

  assign state        = state_r;
  assign flash_active = active_r;

endmodule

// File: rtl/sprite_palette_engine.sv
// Multi-palette color lookup with one-cycle registered output, per-channel
// fade shift, transparent index 0 and a frame-based hit-flash override.
module sprite_palette_engine
  import sprite_palette_engine_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int NUM_PAL = 4,
  parameter int CH_W    = DEF_CH_W,
  parameter int FLASH_W = 6
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [INDEX_W-1:0]         wr_index,
  input  logic [3*CH_W-1:0]          wr_rgb,
  input  logic                       rd_valid,
  input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
  input  logic [INDEX_W-1:0]         rd_index,
  input  logic                       frame_tick,
  input  logic                       flash_start,
  input  logic [FLASH_W-1:0]         flash_frames,
  input  logic [1:0]                 fade_shift,
  output logic                       out_valid,
  output logic                       transparent,
  output logic [CH_W-1:0]            red,
  output logic [CH_W-1:0]            green,
  output logic [CH_W-1:0]            blue,
  output logic                       flash_active
);

  localparam int PAL_W   = $clog2(NUM_PAL);
  localparam int ADDR_W  = PAL_W + INDEX_W;
  localparam int ENTRIES = 1 << ADDR_W;

  logic [3*CH_W-1:0] mem_r [ENTRIES];
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic [3*CH_W-1:0] entry_s;
  flash_state_e      flash_state_s;

  logic              valid_r, transp_r, valid_n, transp_n;
  logic [CH_W-1:0]   red_r, green_r, blue_r, red_n, green_n, blue_n;

  palette_flash_fsm #(.FLASH_W(FLASH_W)) u_fsm (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .frame_tick   (frame_tick),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .state        (flash_state_s),
    .flash_active (flash_active)
  );

  assign wr_addr_s = {wr_pal, wr_index};
  assign rd_addr_s = {rd_pal, rd_index};
  assign entry_s   = mem_r[rd_addr_s];

  // Palette storage; reads see the pre-write contents of a colliding entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= {(3*CH_W){1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_addr_s] <= wr_rgb;
    end else begin
      mem_r[wr_addr_s] <= mem_r[wr_addr_s];
    end
  end

  // Lookup result: transparent beats flash, flash beats fade.
  always_comb begin
    valid_n  = 1'b0;
    transp_n = 1'b0;
    red_n    = {CH_W{1'b0}};
    green_n  = {CH_W{1'b0}};
    blue_n   = {CH_W{1'b0}};
    if (rd_valid) begin
      valid_n = 1'b1;
      if (rd_index == {INDEX_W{1'b0}}) begin
        transp_n = 1'b1;
      end else if (flash_state_s == FLASH_ON) begin
        red_n   = {CH_W{1'b1}};
        green_n = {CH_W{1'b1}};
        blue_n  = {CH_W{1'b1}};
      end else begin
        red_n   = entry_s[3*CH_W-1 -: CH_W] >> fade_shift;
        green_n = entry_s[2*CH_W-1 -: CH_W] >> fade_shift;
        blue_n  = entry_s[CH_W-1   -: CH_W] >> fade_shift;
      end
    end else begin
      valid_n = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_r  <= 1'b0;
      transp_r <= 1'b0;
      red_r    <= {CH_W{1'b0}};
      green_r  <= {CH_W{1'b0}};
      blue_r   <= {CH_W{1'b0}};
    end else begin
      valid_r  <= valid_n;
      transp_r <= transp_n;
      red_r    <= red_n;
      green_r  <= green_n;
      blue_r   <= blue_n;
    end
  end

  assign out_valid   = valid_r;
  assign transparent = transp_r;
  assign red         = red_r;
  assign green       = green_r;
  assign blue        = blue_r;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed bench for sprite_palette_engine: each driven cycle pushes its
// expected output word {valid,transparent,r,g,b}, popped one edge later.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        wr_en, rd_valid, frame_tick, flash_start;
  logic [1:0]  wr_pal, rd_pal, fade_shift;
  logic [3:0]  wr_index, rd_index;
  logic [11:0] wr_rgb;
  logic [5:0]  flash_frames;
  logic        out_valid, transparent, flash_active;
  logic [3:0]  red, green, blue;

  int passed = 0;
  int total  = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];

  sprite_palette_engine dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_index(rd_index),
    .frame_tick(frame_tick), .flash_start(flash_start), .flash_frames(flash_frames),
    .fade_shift(fade_shift),
    .out_valid(out_valid), .transparent(transparent),
    .red(red), .green(green), .blue(blue), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total = total + 1;
    assert (obs === expv) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [1:0] p, input logic [3:0] i, input logic [11:0] rgb);
    wr_en = 1'b1; wr_pal = p; wr_index = i; wr_rgb = rgb;
  endtask

  task automatic rd(input logic [1:0] p, input logic [3:0] i, input logic [1:0] f,
                    input logic [13:0] expv, input string tag);
    rd_valid = 1'b1; rd_pal = p; rd_index = i; fade_shift = f;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  // Advance one edge and compare the output word that edge produced.
  task automatic cycle();
    logic [13:0] e;
    string t;
    if (!rd_valid) begin
      exp_q.push_back(14'h0000);
      tag_q.push_back("idle");
    end
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {2'b00, out_valid, transparent, red, green, blue}, {2'b00, e});
    wr_en = 1'b0; rd_valid = 1'b0; frame_tick = 1'b0; flash_start = 1'b0;
  endtask

  task automatic chk_active(input string tag, input logic expv);
    chk(tag, {15'd0, flash_active}, {15'd0, expv});
  endtask

  initial begin
    Reset_n = 1'b0; wr_en = 1'b0; rd_valid = 1'b0; frame_tick = 1'b0;
    flash_start = 1'b0; wr_pal = 2'd0; rd_pal = 2'd0; wr_index = 4'd0;
    rd_index = 4'd0; wr_rgb = 12'h000; flash_frames = 6'd0; fade_shift = 2'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outputs", {2'b00, out_valid, transparent, red, green, blue}, 16'h0000);
    chk_active("reset_active", 1'b0);
    Reset_n = 1'b1;

    // Basic lookup, fade and transparency.
    wr(2'd1, 4'd5, 12'hC58);                          cycle();
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "read_c58"); cycle();
    rd(2'd1, 4'd5, 2'd2, {2'b10, 12'h312}, "fade2");    cycle();
    rd(2'd1, 4'd0, 2'd0, {2'b11, 12'h000}, "transp");   cycle();
    // Read-during-write returns the old entry.
    wr(2'd0, 4'd3, 12'hFFF);
    rd(2'd0, 4'd3, 2'd0, {2'b10, 12'h000}, "rdw_old");  cycle();
    rd(2'd0, 4'd3, 2'd0, {2'b10, 12'hFFF}, "rdw_new");  cycle();
    rd(2'd0, 4'd3, 2'd3, {2'b10, 12'h111}, "fade3");    cycle();
    // Highest palette / index corner, and a neighbour that stays clear.
    wr(2'd3, 4'd15, 12'hA5F);                          cycle();
    rd(2'd3, 4'd15, 2'd1, {2'b10, 12'h527}, "pal3_i15"); cycle();
    rd(2'd1, 4'd15, 2'd0, {2'b10, 12'h000}, "pal1_i15"); cycle();

    // Flash of 3 frames: ON, OFF, ON, IDLE.
    flash_start = 1'b1; flash_frames = 6'd3;           cycle();
    chk_active("flash_on", 1'b1);
    rd(2'd1, 4'd5, 2'd2, {2'b10, 12'hFFF}, "on_ignores_fade"); cycle();
    frame_tick = 1'b1;
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hFFF}, "on_tick1");  cycle();
    chk_active("off_after_tick1", 1'b1);
    frame_tick = 1'b1;
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "off_tick2"); cycle();
    chk_active("on_after_tick2", 1'b1);
    frame_tick = 1'b1;
    rd(2'd1, 4'd0, 2'd0, {2'b11, 12'h000}, "on_transp"); cycle();
    chk_active("idle_after_tick3", 1'b0);
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "idle_read"); cycle();

    // Restart during OFF with a coincident tick: ON with a fresh count of 2.
    flash_start = 1'b1; flash_frames = 6'd3;           cycle();
    frame_tick = 1'b1;                                 cycle();
    chk_active("restart_pre_off", 1'b1);
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "restart_in_off");
    flash_start = 1'b1; flash_frames = 6'd2; frame_tick = 1'b1; cycle();
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hFFF}, "restart_on"); frame_tick = 1'b1; cycle();
    chk_active("restart_tick1", 1'b1);
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "restart_off"); frame_tick = 1'b1; cycle();
    chk_active("restart_tick2_idle", 1'b0);

    // Zero-length start cancels a running flash.
    flash_start = 1'b1; flash_frames = 6'd5;           cycle();
    flash_start = 1'b1; flash_frames = 6'd0;           cycle();
    chk_active("cancel", 1'b0);
    rd(2'd1, 4'd5, 2'd0, {2'b10, 12'hC58}, "cancel_read"); cycle();

    // Asynchronous reset mid-flash with a lookup in flight.
    flash_start = 1'b1; flash_frames = 6'd4;           cycle();
    chk_active("pre_reset_on", 1'b1);
    rd_valid = 1'b1; rd_pal = 2'd1; rd_index = 4'd5;
    #2 Reset_n = 1'b0;
    #1;
    chk("reset_async_outputs", {2'b00, out_valid, transparent, red, green, blue}, 16'h0000);
    chk_active("reset_async_active", 1'b0);
    rd_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    chk_active("post_reset_active", 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        rd(p[1:0], i[3:0], 2'd0, (i == 0) ? {2'b11, 12'h000} : {2'b10, 12'h000}, "cleared");
        cycle();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
